change_dispenser: RTL

//  Payout end of the vending coin interface. Accepts a change request (rupee amount)

---
 rtl/change_dispenser_if.sv | 34 +++
 rtl/change_dispenser.sv | 118 +++++++++++
 2 files changed

// File: rtl/change_dispenser_if.sv
// Change-payout bus between the vending controller, the dispenser and the hopper driver.
// With PAYOUT_TALLY_EN defined the bus also carries the running total_paid tally.
interface change_dispenser_if #(
  parameter int AMT_W = 8
);
  logic             change_req;
  logic [AMT_W-1:0] change_amt;
  logic             hopper_ready;
  logic             coin10_empty;
  logic             pay_10;
  logic             pay_5;
  logic             busy;
  logic             done;
  logic             err;
`ifdef PAYOUT_TALLY_EN
  logic [15:0]      total_paid;
`endif

  modport master (
    output change_req, change_amt, hopper_ready, coin10_empty,
`ifdef PAYOUT_TALLY_EN
    input  total_paid,
`endif
    input  pay_10, pay_5, busy, done, err
  );

  modport slave (
    input  change_req, change_amt, hopper_ready, coin10_empty,
`ifdef PAYOUT_TALLY_EN
    output total_paid,
`endif
    output pay_10, pay_5, busy, done, err
  );
endinterface

// File: rtl/change_dispenser.sv
// Change payout: pays a rupee amount as Rs10 coins first, then Rs5, via eject pulses.
// Optional PAYOUT_TALLY_EN adds a saturating total_paid tally on the bus.
module change_dispenser #(
  parameter int AMT_W   = 8,
  parameter int GAP_CYC = 4
) (
  input  logic               clk,
  input  logic               reset,
  change_dispenser_if.slave  bus
);
  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_PAY, S_GAP, S_DONE} state_t;

  state_t           state, state_n;
  logic [AMT_W-1:0] rem, rem_n;
  logic [GW-1:0]    gcnt, gcnt_n;
  logic             pay10_q, pay5_q, busy_q, done_q, err_q;
  logic             pay10_n, pay5_n, done_n, err_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      rem     <= '0;
      gcnt    <= '0;
      pay10_q <= 1'b0;
      pay5_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_n;
      rem     <= rem_n;
      gcnt    <= gcnt_n;
      pay10_q <= pay10_n;
      pay5_q  <= pay5_n;
      busy_q  <= (state_n != S_IDLE);
      done_q  <= done_n;
      err_q   <= err_n;
    end
  end

  // Pulses are registered on the CHECK->PAY edge so they appear during PAY.
  always_comb begin
    state_n = state;
    rem_n   = rem;
    gcnt_n  = gcnt;
    pay10_n = 1'b0;
    pay5_n  = 1'b0;
    done_n  = 1'b0;
    err_n   = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.change_req) begin
          if ((bus.change_amt % AMT_W'(5)) != '0) begin
            err_n = 1'b1;
          end else if (bus.change_amt == '0) begin
            state_n = S_DONE;
          end else begin
            rem_n   = bus.change_amt;
            state_n = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        if (rem == '0) begin
          state_n = S_DONE;
        end else if (bus.hopper_ready) begin
          state_n = S_PAY;
          if (rem >= AMT_W'(10) && !bus.coin10_empty) begin
            pay10_n = 1'b1;
            rem_n   = rem - AMT_W'(10);
          end else begin
            pay5_n  = 1'b1;
            rem_n   = rem - AMT_W'(5);
          end
        end
      end
      S_PAY: begin
        gcnt_n  = '0;
        state_n = S_GAP;
      end
      S_GAP: begin
        if (gcnt == GW'(GAP_CYC - 1)) state_n = S_CHECK;
        else                          gcnt_n  = gcnt + GW'(1);
      end
      S_DONE: begin
        done_n  = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign bus.pay_10 = pay10_q;
  assign bus.pay_5  = pay5_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.err    = err_q;

`ifdef PAYOUT_TALLY_EN
  logic [15:0] tally;
  logic [16:0] tally_sum;

  always_comb begin
    tally_sum = {1'b0, tally};
    if (pay10_q)     tally_sum = {1'b0, tally} + 17'd10;
    else if (pay5_q) tally_sum = {1'b0, tally} + 17'd5;
  end

  always_ff @(posedge clk) begin
    if (reset)                 tally <= '0;
    else if (pay10_q || pay5_q) tally <= tally_sum[16] ? 16'hFFFF : tally_sum[15:0];
  end

  assign bus.total_paid = tally;
`endif
endmodule
